// File: rtl/multi_alarm_watch_pkg.sv
// Shared definitions for the multi-channel alarm unit: field selectors, cursor
// encodings, FSM states, BCD limits and a BCD increment helper.
// Optional snooze feature is enabled by defining ALARM_SNOOZE_EN.
package multi_alarm_watch_pkg;

  // Field selectors for the edit cursor
  localparam logic [1:0] FLD_HOUR = 2'd1;
  localparam logic [1:0] FLD_MIN  = 2'd2;

  // Cursor encodings presented on cursor_pos
  localparam logic [1:0] CUS_HOUR = 2'b10;
  localparam logic [1:0] CUS_MIN  = 2'b01;
  localparam logic [1:0] CUS_NONE = 2'b00;

  // BCD limits, packed {tens, ones}
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRing   = 2'd1,
    StSnooze = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRing = 2'd1
  } state_e;
`endif

  // Increment a packed {tens, ones} BCD field, wrapping to 00 after max
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

endpackage

// File: rtl/multi_alarm_watch_slot.sv
// One alarm channel: BCD HH:MM storage, enable bit and rising-edge match detect.
// A hit fires only on the cycle the slot starts matching the running time, so
// enabling an already-matching slot stays quiet while editing onto it rings.
module alarm_slot
  import multi_alarm_watch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_inc_hour,
  input  logic        i_inc_min,
  input  logic        i_toggle,
  input  logic [15:0] i_time_now,
  output logic [15:0] o_value,
  output logic        o_on,
  output logic        o_hit
);

  logic [7:0] r_hour;  // {tens, ones}
  logic [7:0] r_min;   // {tens, ones}
  logic       r_on;
  logic       r_cmp_q;
  logic       w_cmp;

  // Repack into {min1, min10, hour1, hour10} to line up with time_now
  assign o_value = {r_min[3:0], r_min[7:4], r_hour[3:0], r_hour[7:4]};
  assign w_cmp   = (o_value == i_time_now);
  assign o_on    = r_on;
  assign o_hit   = r_on & w_cmp & ~r_cmp_q;

  // Slot storage, enable and registered raw compare
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour  <= 8'h00;
      r_min   <= 8'h00;
      r_on    <= 1'b0;
      r_cmp_q <= 1'b0;
    end else begin
      r_cmp_q <= w_cmp;
      if (i_inc_hour) r_hour <= bcd_inc(r_hour, HOUR_MAX);
      if (i_inc_min)  r_min  <= bcd_inc(r_min, MIN_MAX);
      if (i_toggle)   r_on   <= ~r_on;
    end
  end

endmodule

// File: rtl/multi_alarm_watch.sv
// N-channel alarm unit top: channel select, edit cursor, ringing FSM with
// auto-timeout, and output muxes for the display and buzzer.
// Define ALARM_SNOOZE_EN to build the SNOOZE state and its counter.
module multi_alarm_watch
  import multi_alarm_watch_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 4,
  localparam int unsigned CH_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  parameter int unsigned RING_SEC = 60
`ifdef ALARM_SNOOZE_EN
  ,
  parameter int unsigned SNOOZE_MIN = 5
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            btn,
  input  logic [15:0]           time_now,
  input  logic                  sec_tick,
  output logic [15:0]           value,
  output logic [1:0]            cursor_pos,
  output logic [CH_W-1:0]       sel_ch,
  output logic [NUM_ALARMS-1:0] alarm_on,
  output logic                  ringing,
  output logic [CH_W-1:0]       ring_ch
);

  localparam int unsigned RC_W = $clog2(RING_SEC + 1);
`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
  localparam int unsigned SNZ_W     = $clog2(SNZ_TICKS + 1);
`endif

  state_e            r_state, w_state_d;
  logic [CH_W-1:0]   r_sel, w_sel_d;
  logic [1:0]        r_field, w_field_d;
  logic [CH_W-1:0]   r_ring_ch, w_ring_ch_d;
  logic [RC_W-1:0]   r_ring_cnt, w_ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]  r_snz_cnt, w_snz_cnt_d;
`endif

  logic                  w_toggle;
  logic                  w_inc_hour;
  logic                  w_inc_min;
  logic [NUM_ALARMS-1:0] w_hit;
  logic                  w_hit_any;
  logic [CH_W-1:0]       w_hit_ch;
  logic [15:0]           w_slot_val [NUM_ALARMS];

  for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_slot
    logic w_sel_here;
    assign w_sel_here = (r_sel == CH_W'(g));

    alarm_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .i_inc_hour (w_inc_hour & w_sel_here),
      .i_inc_min  (w_inc_min & w_sel_here),
      .i_toggle   (w_toggle & w_sel_here),
      .i_time_now (time_now),
      .o_value    (w_slot_val[g]),
      .o_on       (alarm_on[g]),
      .o_hit      (w_hit[g])
    );
  end

  // Edit decode: only in IDLE, one action per cycle in fixed button priority
  always_comb begin
    w_toggle   = 1'b0;
    w_inc_hour = 1'b0;
    w_inc_min  = 1'b0;
    w_sel_d    = r_sel;
    w_field_d  = r_field;
    if (r_state == StIdle) begin
      if (btn[0]) begin
        w_toggle = 1'b1;
      end else if (btn[3]) begin
        w_sel_d = (r_sel == CH_W'(NUM_ALARMS - 1)) ? '0 : r_sel + 1'b1;
      end else if (btn[1]) begin
        w_field_d = (r_field == FLD_HOUR) ? FLD_MIN : FLD_HOUR;
      end else if (btn[2]) begin
        if (r_field == FLD_HOUR) w_inc_hour = 1'b1;
        else                     w_inc_min  = 1'b1;
      end
    end
  end

  // Lowest-index hit channel
  always_comb begin
    w_hit_any = |w_hit;
    w_hit_ch  = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_ch = CH_W'(i);
    end
  end

  // Ringing FSM next state; buttons take precedence over sec_tick
  always_comb begin
    w_state_d    = r_state;
    w_ring_ch_d  = r_ring_ch;
    w_ring_cnt_d = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
    w_snz_cnt_d  = r_snz_cnt;
`endif
    case (r_state)
      StIdle: begin
        w_ring_cnt_d = '0;
        if (w_hit_any) begin
          w_state_d   = StRing;
          w_ring_ch_d = w_hit_ch;
        end
      end
      StRing: begin
        if (btn[0]) begin
          w_state_d    = StIdle;
          w_ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
        end else if (btn[2]) begin
          w_state_d    = StSnooze;
          w_ring_cnt_d = '0;
          w_snz_cnt_d  = '0;
`endif
        end else if (sec_tick) begin
          if (r_ring_cnt == RC_W'(RING_SEC - 1)) begin
            w_state_d    = StIdle;
            w_ring_cnt_d = '0;
          end else begin
            w_ring_cnt_d = r_ring_cnt + 1'b1;
          end
        end
      end
`ifdef ALARM_SNOOZE_EN
      StSnooze: begin
        if (btn[0]) begin
          w_state_d   = StIdle;
          w_snz_cnt_d = '0;
        end else if (w_hit_any) begin
          // A fresh alarm supersedes the pending snooze
          w_state_d    = StRing;
          w_ring_ch_d  = w_hit_ch;
          w_ring_cnt_d = '0;
          w_snz_cnt_d  = '0;
        end else if (sec_tick) begin
          if (r_snz_cnt == SNZ_W'(SNZ_TICKS - 1)) begin
            w_state_d    = StRing;
            w_ring_cnt_d = '0;
            w_snz_cnt_d  = '0;
          end else begin
            w_snz_cnt_d = r_snz_cnt + 1'b1;
          end
        end
      end
`endif
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State, selection, cursor and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_sel      <= '0;
      r_field    <= FLD_HOUR;
      r_ring_ch  <= '0;
      r_ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt  <= '0;
`endif
    end else begin
      r_state    <= w_state_d;
      r_sel      <= w_sel_d;
      r_field    <= w_field_d;
      r_ring_ch  <= w_ring_ch_d;
      r_ring_cnt <= w_ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
      r_snz_cnt  <= w_snz_cnt_d;
`endif
    end
  end

  // Output muxes; cursor hidden whenever the FSM is not idle
  always_comb begin
    value      = w_slot_val[r_sel];
    sel_ch     = r_sel;
    ring_ch    = r_ring_ch;
    ringing    = (r_state == StRing);
    cursor_pos = CUS_NONE;
    if (r_state == StIdle) begin
      cursor_pos = (r_field == FLD_MIN) ? CUS_MIN : CUS_HOUR;
    end
  end

endmodule

// File: tb/tb_multi_alarm_watch.sv
// Self-checking bench for multi_alarm_watch (default parameters).
module tb_multi_alarm_watch;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn;
  logic [15:0] time_now;
  logic        sec_tick;
  logic [15:0] value;
  logic [1:0]  cursor_pos;
  logic [1:0]  sel_ch;
  logic [3:0]  alarm_on;
  logic        ringing;
  logic [1:0]  ring_ch;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] T_NONE = 16'h9999;  // never equals a valid slot

  multi_alarm_watch dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .time_now   (time_now),
    .sec_tick   (sec_tick),
    .value      (value),
    .cursor_pos (cursor_pos),
    .sel_ch     (sel_ch),
    .alarm_on   (alarm_on),
    .ringing    (ringing),
    .ring_ch    (ring_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  btn;
    logic [15:0] value;
    logic [1:0]  cur;
    logic [1:0]  sel;
    logic [3:0]  on;
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b);
    btn = b;
    step();
    btn = 4'b0000;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    btn      = 4'b0000;
    time_now = T_NONE;
    sec_tick = 1'b0;

    // Edit-path vectors from reset; slot values packed {m1,m10,h1,h10}
    vecs[0] = '{4'b0100, 16'h0010, 2'b10, 2'd0, 4'b0000};  // hour 00->01
    vecs[1] = '{4'b0010, 16'h0010, 2'b01, 2'd0, 4'b0000};  // cursor -> min
    vecs[2] = '{4'b0100, 16'h1010, 2'b01, 2'd0, 4'b0000};  // min 00->01
    vecs[3] = '{4'b1000, 16'h0000, 2'b01, 2'd1, 4'b0000};  // next channel
    vecs[4] = '{4'b0001, 16'h0000, 2'b01, 2'd1, 4'b0010};  // enable ch1
    vecs[5] = '{4'b1111, 16'h0000, 2'b01, 2'd1, 4'b0000};  // btn0 wins
    vecs[6] = '{4'b1110, 16'h0000, 2'b01, 2'd2, 4'b0000};  // btn3 wins
    vecs[7] = '{4'b0110, 16'h0000, 2'b10, 2'd2, 4'b0000};  // btn1 beats btn2
    vecs[8] = '{4'b1000, 16'h0000, 2'b10, 2'd3, 4'b0000};
    vecs[9] = '{4'b1000, 16'h1010, 2'b10, 2'd0, 4'b0000};  // wrap 3 -> 0

    step();
    step();
    reset = 1'b0;

    // Reset state
    check("rst_value", value, 16'h0000);
    check("rst_cursor", {14'd0, cursor_pos}, 16'h0002);
    check("rst_sel", {14'd0, sel_ch}, 16'h0000);
    check("rst_on", {12'd0, alarm_on}, 16'h0000);
    check("rst_ring", {15'd0, ringing}, 16'h0000);
    check("rst_ring_ch", {14'd0, ring_ch}, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      press(vecs[i].btn);
      check($sformatf("vec%0d_value", i), value, vecs[i].value);
      check($sformatf("vec%0d_cursor", i), {14'd0, cursor_pos}, {14'd0, vecs[i].cur});
      check($sformatf("vec%0d_sel", i), {14'd0, sel_ch}, {14'd0, vecs[i].sel});
      check($sformatf("vec%0d_on", i), {12'd0, alarm_on}, {12'd0, vecs[i].on});
      check($sformatf("vec%0d_ring", i), {15'd0, ringing}, 16'h0000);
    end

    // Program ch0 to 07:30 and arm it
    do_reset();
    for (int i = 0; i < 7; i++) press(4'b0100);
    press(4'b0010);
    for (int i = 0; i < 30; i++) press(4'b0100);
    press(4'b0001);
    check("prog_value", value, 16'h0370);
    check("prog_on", {12'd0, alarm_on}, 16'h0001);
    check("prog_cursor", {14'd0, cursor_pos}, 16'h0001);

    // 07:29 -> 07:30 rings one edge later, auto-stops after 60 ticks
    time_now = 16'h9270;
    step();
    check("pre_match_ring", {15'd0, ringing}, 16'h0000);
    time_now = 16'h0370;
    step();
    check("match_ring", {15'd0, ringing}, 16'h0001);
    check("match_ring_ch", {14'd0, ring_ch}, 16'h0000);
    check("ring_cursor", {14'd0, cursor_pos}, 16'h0000);
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 59) check("ring_59", {15'd0, ringing}, 16'h0001);
      if (k == 60) check("ring_60", {15'd0, ringing}, 16'h0000);
    end
    for (int i = 0; i < 5; i++) step();
    check("no_retrigger", {15'd0, ringing}, 16'h0000);

    // Retrigger by leaving and re-entering 07:30
    time_now = 16'h9270;
    step();
    time_now = 16'h0370;
    step();
    check("retrig_ring", {15'd0, ringing}, 16'h0001);
`ifdef ALARM_SNOOZE_EN
    press(4'b0100);
    check("snooze_ring", {15'd0, ringing}, 16'h0000);
    check("snooze_cursor", {14'd0, cursor_pos}, 16'h0000);
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 299) check("snooze_299", {15'd0, ringing}, 16'h0000);
      if (k == 300) check("snooze_300", {15'd0, ringing}, 16'h0001);
    end
    check("snooze_ring_ch", {14'd0, ring_ch}, 16'h0000);
    press(4'b0100);
    press(4'b0001);
    check("snooze_stop_cursor", {14'd0, cursor_pos}, 16'h0001);
    for (int i = 0; i < 300; i++) tick();
    check("snooze_stop_ring", {15'd0, ringing}, 16'h0000);
`else
    press(4'b0100);
    check("btn2_ignored_ring", {15'd0, ringing}, 16'h0001);
    check("btn2_ignored_value", value, 16'h0370);
    press(4'b0001);
    check("stop_ring", {15'd0, ringing}, 16'h0000);
    check("stop_on", {12'd0, alarm_on}, 16'h0001);
`endif

    // Channels 1 and 3 at 12:00 fire together; lowest wins
    do_reset();
    time_now = T_NONE;
    press(4'b1000);
    for (int i = 0; i < 12; i++) press(4'b0100);
    press(4'b0001);
    press(4'b1000);
    press(4'b1000);
    for (int i = 0; i < 12; i++) press(4'b0100);
    press(4'b0001);
    check("dual_value", value, 16'h0021);
    check("dual_on", {12'd0, alarm_on}, 16'h000a);
    time_now = 16'h0021;
    step();
    check("dual_ring", {15'd0, ringing}, 16'h0001);
    check("dual_ring_ch", {14'd0, ring_ch}, 16'h0001);
    press(4'b1000);
    check("ring_sel_ignored", {14'd0, sel_ch}, 16'h0003);
    press(4'b0001);
    check("dual_stop", {15'd0, ringing}, 16'h0000);
    check("dual_stop_on", {12'd0, alarm_on}, 16'h000a);
    for (int i = 0; i < 3; i++) step();
    check("dual_no_retrigger", {15'd0, ringing}, 16'h0000);

    // Enabling a matching slot stays quiet; editing onto the time rings
    do_reset();
    time_now = 16'h0000;
    step();
    step();
    press(4'b0001);
    step();
    step();
    check("enable_match_quiet", {15'd0, ringing}, 16'h0000);
    time_now = 16'h1000;
    step();
    press(4'b0010);
    press(4'b0100);
    check("edit_pre_ring", {15'd0, ringing}, 16'h0000);
    step();
    check("edit_onto_ring", {15'd0, ringing}, 16'h0001);

    // Reset in the middle of a ring
    do_reset();
    time_now = T_NONE;
    check("rst_ring_ringing", {15'd0, ringing}, 16'h0000);
    check("rst_ring_on", {12'd0, alarm_on}, 16'h0000);
    check("rst_ring_cursor", {14'd0, cursor_pos}, 16'h0002);
    check("rst_ring_ch", {14'd0, ring_ch}, 16'h0000);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rst_ring_sel%0d", c), {14'd0, sel_ch}, c[15:0]);
      check($sformatf("rst_ring_val%0d", c), value, 16'h0000);
      press(4'b1000);
    end

    // Hour and minute wrap, minute without carry
    for (int i = 0; i < 23; i++) press(4'b0100);
    check("hour_23", value, 16'h0032);
    press(4'b0100);
    check("hour_wrap", value, 16'h0000);
    press(4'b0100);
    press(4'b0010);
    for (int i = 0; i < 59; i++) press(4'b0100);
    check("min_59", value, 16'h9510);
    press(4'b0100);
    check("min_wrap", value, 16'h0010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_alarm_watch.md
Name: multi_alarm_watch

Overview:
- Parametrised N-channel alarm unit, successor to the single-alarm set/alarm block.
- Each channel stores a BCD HH:MM alarm time and its own enable bit.
- The block compares every channel against the running clock time and drives a ringing state machine with auto-timeout and snooze.
- Sits beside the time-keeping counter; its outputs feed the FND display mux and the buzzer driver.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..8).
- RING_SEC, 60, seconds the alarm rings before auto-stop (1..255).
- SNOOZE_MIN, 5, snooze delay in minutes (1..15). Used only with SNOOZE_EN.
- CH_W, derived localparam = max(1, clog2(NUM_ALARMS)), channel index width.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where it is high
- btn  input  4  single-cycle debounced pulses: [0] enable toggle/stop, [1] cursor hour<->min, [2] increment/snooze, [3] next channel
- time_now  input  16  current time, packed {min1,min10,hour1,hour10}, BCD nibbles
- sec_tick  input  1  one-cycle pulse per second
- value  output  16  selected channel alarm time, same packing as time_now
- cursor_pos  output  2  CUS_HOUR while editing hour, CUS_MIN while editing minute, 0 while ringing or snoozing
- sel_ch  output  CH_W  channel currently shown and edited
- alarm_on  output  NUM_ALARMS  per-channel enable bits
- ringing  output  1  registered buzzer request
- ring_ch  output  CH_W  channel that caused the current ring or snooze

Behaviour:
Reset:
- All channels 00:00 and disabled; sel_ch=0; cursor on hour.
- FSM=IDLE; ringing=0; ring_ch=0; all counters 0.

Edit (FSM=IDLE only):
- btn[3]: sel_ch+1, wraps NUM_ALARMS-1 -> 0.
- btn[1]: toggles cursor between hour and minute.
- btn[2]: increments the field under the cursor. Hour 23 -> 00. Minute 59 -> 00 with no carry into hour.
- btn[0]: toggles alarm_on[sel_ch].
- Simultaneous button pulses are handled in priority order btn[0] > btn[3] > btn[1] > btn[2]; only one action per cycle.

Match detect (per channel):
- cmp_i = (slot_i == time_now). cmp_q_i registers raw cmp_i every cycle.
- hit_i = alarm_on[i] & cmp_i & ~cmp_q_i.
- Enabling a channel mid-minute that already matches does not ring.
- Editing a slot onto the current time while it is enabled does ring.

FSM states IDLE, RING, SNOOZE:
- IDLE -> RING on any hit. ring_ch = lowest-index hit channel. ring_cnt=0. ringing rises one clk after time_now changes.
- RING:
  - ring_cnt increments on sec_tick; reaching RING_SEC -> IDLE.
  - btn[0] -> IDLE (stop; enable bit is not toggled).
  - btn[2] -> SNOOZE (SNOOZE_EN only).
  - Hits from other channels are ignored.
  - All other buttons are ignored.
- SNOOZE:
  - snz_cnt increments on sec_tick; reaching SNOOZE_MIN*60 -> RING with ring_cnt=0.
  - btn[0] -> IDLE.
  - A new hit -> RING with ring_ch = the new channel; the snooze is discarded.
  - Other buttons are ignored.
- Disabling is impossible outside IDLE, so ring_ch always refers to an enabled channel.
- ringing = (state==RING), registered.
- sec_tick and a button pulse in the same cycle: the button wins and the counter does not advance.
- Reset asserted mid-ring or mid-snooze returns everything to reset values on that edge.

Optional Feature:
- Macro ALARM_SNOOZE_EN.
- Defined: SNOOZE state, snz_cnt (width clog2(SNOOZE_MIN*60+1)), and btn[2] snooze in RING all exist.
- Undefined: no SNOOZE state and no snz_cnt; btn[2] is ignored in RING; SNOOZE_MIN is unused.

Decomposition:
- Shared defines/package holds:
  - Field selectors HOUR=2'd1, MIN=2'd2.
  - Cursor encodings CUS_HOUR=2'b10, CUS_MIN=2'b01.
  - FSM state encodings IDLE=0, RING=1, SNOOZE=2.
  - BCD limits (hour 23, minute 59).
- One sub-module, alarm_slot, instantiated NUM_ALARMS times via generate.
  - Holds BCD hour/min, enable, inc_hour/inc_min/toggle inputs, cmp_q and hit output.
- The top level holds the channel select, cursor, FSM, counters and output muxes.

Test Plan:
1. Reset, then btn[2]x7 on hour, btn[1], btn[2]x30, btn[0] -> value={0,3,7,0} (07:30), alarm_on=4'b0001, cursor_pos=CUS_MIN.
2. Channel 0 armed at 07:30; time_now steps 07:29 -> 07:30 -> ringing=1 next clk, ring_ch=0. After 60 sec_ticks -> ringing=0, no retrigger while time_now stays 07:30.
3. Channels 1 and 3 both armed at 12:00; time_now hits 12:00 -> ring_ch=1. btn[0] stops the ring, alarm_on unchanged.
4. ALARM_SNOOZE_EN defined, ringing: btn[2] -> ringing=0. After exactly 300 sec_ticks -> ringing=1 again, ring_ch unchanged. btn[0] during snooze -> IDLE.
5. Wrap checks: hour 23 + btn[2] -> 00; minute 59 + btn[2] -> 00 with hour unchanged; sel_ch=3 + btn[3] -> 0.
6. Reset asserted during RING -> next edge ringing=0, all alarm_on=0, all values 00:00.
